// File: rtl/residual_arbiter.sv
// residual_arbiter
//   Round-robin arbiter and sequencer that shares one residual saturating-add
//   unit among N_REQ requesters. It picks one request, muxes that requester's
//   operands onto the unit, pulses res_start, waits for res_done, registers
//   the sum into y_out and acknowledges the winner.
//
//   Optional feature macro: RESIDUAL_ARB_WDOG_EN
//     When defined, a watchdog aborts a job that has waited WDOG_CYCLES
//     without res_done. The winner gets ack and err together, and y_out
//     keeps its old value. When undefined, the wait is unbounded and err
//     is tied to 0.
//
//   Ports
//     clk, rst_n         clock (rising edge), async active-low reset
//     req                level request, one bit per requester
//     req_x, req_sub     per-requester operands, slice [r*NDATA +: NDATA]
//     gnt                one-hot registered grant
//     ack                one-cycle completion pulse to the winner
//     err                one-cycle watchdog-abort pulse, concurrent with ack
//     y_out              registered result, broadcast to all requesters
//     res_start          start pulse to the residual unit
//     res_x, res_sub     operands to the residual unit, muxed by gnt
//     res_done, res_y    completion and result from the residual unit
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | no job; arbitrate among req, starting after last winner
//   S_ISSUE  | gnt set, res_start high for this single cycle
//   S_WAIT   | gnt held, waiting for res_done (or watchdog expiry)
//   S_ACK    | gnt cleared, ack (and err on abort) pulse to the winner
module residual_arbiter #(
    parameter  int DATA_WIDTH  = 16,
    parameter  int SEQ_LEN     = 8,
    parameter  int EMB_DIM     = 8,
    parameter  int N_REQ       = 2,
    parameter  int WDOG_CYCLES = 256,
    localparam int NDATA       = DATA_WIDTH * SEQ_LEN * EMB_DIM
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*NDATA-1:0] req_x,
    input  logic [N_REQ*NDATA-1:0] req_sub,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       err,
    output logic [NDATA-1:0]       y_out,
    output logic                   res_start,
    output logic [NDATA-1:0]       res_x,
    output logic [NDATA-1:0]       res_sub,
    input  logic                   res_done,
    input  logic [NDATA-1:0]       res_y
);

    localparam int LAST_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t              r_state;
    logic [LAST_W-1:0]   r_last;
    logic [N_REQ-1:0]    r_gnt;
    logic [N_REQ-1:0]    r_ack;
    logic                r_res_start;
    logic [NDATA-1:0]    r_y;

    logic [LAST_W-1:0]   w_win;
    logic                w_any;
    logic                w_wdog_expire;
    logic [NDATA-1:0]    w_res_x;
    logic [NDATA-1:0]    w_res_sub;

    // Search starts one past the last winner and wraps, so the last winner
    // is considered only after every other requester.
    always_comb begin : rr_pick
        int v_idx;
        w_win = r_last;
        w_any = 1'b0;
        v_idx = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            v_idx = int'(r_last) + i;
            if (v_idx >= N_REQ) begin
                v_idx = v_idx - N_REQ;
            end
            if (!w_any && req[v_idx]) begin
                w_any = 1'b1;
                w_win = LAST_W'(v_idx);
            end
        end
    end

    // gnt is one-hot or zero, so OR-ing the masked slices is a plain mux
    // that yields all zeros when nothing is granted.
    always_comb begin
        w_res_x   = '0;
        w_res_sub = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (r_gnt[r]) begin
                w_res_x   = w_res_x   | req_x[r*NDATA +: NDATA];
                w_res_sub = w_res_sub | req_sub[r*NDATA +: NDATA];
            end
        end
    end

`ifdef RESIDUAL_ARB_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] r_wdog_cnt;
    logic [N_REQ-1:0]  r_err;

    assign w_wdog_expire = (r_wdog_cnt == WDOG_W'(WDOG_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wdog_cnt <= '0;
        end else if (r_state == S_WAIT && !w_wdog_expire) begin
            r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
        end
    end

    assign err = r_err;
`else
    assign w_wdog_expire = 1'b0;
    assign err           = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last      <= LAST_W'(N_REQ - 1);
            r_gnt       <= '0;
            r_ack       <= '0;
            r_res_start <= 1'b0;
            r_y         <= '0;
`ifdef RESIDUAL_ARB_WDOG_EN
            r_err       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state     <= S_ISSUE;
                        r_last      <= w_win;
                        r_gnt       <= {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
                        r_res_start <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_state     <= S_WAIT;
                    r_res_start <= 1'b0;
                end
                S_WAIT: begin
                    // res_done wins over a same-cycle watchdog expiry.
                    if (res_done) begin
                        r_state <= S_ACK;
                        r_gnt   <= '0;
                        r_ack   <= r_gnt;
                        r_y     <= res_y;
                    end else if (w_wdog_expire) begin
                        r_state <= S_ACK;
                        r_gnt   <= '0;
                        r_ack   <= r_gnt;
`ifdef RESIDUAL_ARB_WDOG_EN
                        r_err   <= r_gnt;
`endif
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_ack   <= '0;
`ifdef RESIDUAL_ARB_WDOG_EN
                    r_err   <= '0;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign ack       = r_ack;
    assign res_start = r_res_start;
    assign y_out     = r_y;
    assign res_x     = w_res_x;
    assign res_sub   = w_res_sub;

endmodule

// File: tb/tb_residual_arbiter.sv
`timescale 1ns/1ps
module tb_residual_arbiter;

    localparam int DW    = 16;
    localparam int SL    = 8;
    localparam int ED    = 8;
    localparam int N     = 2;
    localparam int WD    = 16;
    localparam int NEL   = SL * ED;
    localparam int NDATA = DW * NEL;

    logic               clk     = 1'b0;
    logic               rst_n   = 1'b0;
    logic [N-1:0]       req     = '0;
    logic [N*NDATA-1:0] req_x   = '0;
    logic [N*NDATA-1:0] req_sub = '0;
    logic [N-1:0]       gnt, ack, err;
    logic [NDATA-1:0]   y_out, res_x, res_sub;
    logic [NDATA-1:0]   res_y    = '0;
    logic               res_start;
    logic               res_done = 1'b0;

    int checks   = 0;
    int failures = 0;
    int n_start  = 0;

    residual_arbiter #(
        .DATA_WIDTH (DW),
        .SEQ_LEN    (SL),
        .EMB_DIM    (ED),
        .N_REQ      (N),
        .WDOG_CYCLES(WD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_x    (req_x),
        .req_sub  (req_sub),
        .gnt      (gnt),
        .ack      (ack),
        .err      (err),
        .y_out    (y_out),
        .res_start(res_start),
        .res_x    (res_x),
        .res_sub  (res_sub),
        .res_done (res_done),
        .res_y    (res_y)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    function automatic logic [NDATA-1:0] sat_vec(input logic [NDATA-1:0] x, input logic [NDATA-1:0] s);
        logic [NDATA-1:0] r;
        r = '0;
        for (int e = 0; e < NEL; e++) r[e*DW +: DW] = sat16(x[e*DW +: DW], s[e*DW +: DW]);
        return r;
    endfunction

    function automatic logic [NDATA-1:0] rep(input logic [15:0] v);
        return {NEL{v}};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [NDATA-1:0] act, input logic [NDATA-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int e = 0; e < NEL; e++) begin
                if (act[e*DW +: DW] !== exp[e*DW +: DW]) begin
                    $display("FAIL %s elem %0d got %h expected %h at %0t",
                             name, e, act[e*DW +: DW], exp[e*DW +: DW], $time);
                    break;
                end
            end
        end
    endtask

    // ---------------- reference model (job-level timing rules) ----------------
    int               cyc    = 0;
    int               m_last = N - 1;
    bit               m_job  = 0;
    bit               m_cool = 0;
    bit               m_found;
    int               m_win  = 0;
    int               m_gcyc = 0;
    int               m_age;
    logic [N-1:0]     m_gnt  = '0;
    logic [N-1:0]     m_ack  = '0;
    logic [N-1:0]     m_err  = '0;
    logic             m_start = 1'b0;
    logic [NDATA-1:0] m_y    = '0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_last = N - 1; m_job = 0; m_cool = 0;
            m_gnt = '0; m_ack = '0; m_err = '0; m_start = 1'b0; m_y = '0;
        end else begin
            m_ack = '0; m_err = '0; m_start = 1'b0;
            if (m_job) begin
                // done counts only from the second cycle after the grant on
                m_age = cyc - m_gcyc;
                if (m_age >= 2 && res_done) begin
                    m_ack = '0; m_ack[m_win] = 1'b1;
                    m_gnt = '0; m_job = 0; m_cool = 1;
                    m_y = sat_vec(req_x[m_win*NDATA +: NDATA], req_sub[m_win*NDATA +: NDATA]);
                end
`ifdef RESIDUAL_ARB_WDOG_EN
                else if (m_age == WD + 2) begin
                    m_ack = '0; m_ack[m_win] = 1'b1;
                    m_err = '0; m_err[m_win] = 1'b1;
                    m_gnt = '0; m_job = 0; m_cool = 1;
                end
`endif
            end else if (m_cool) begin
                m_cool = 0;
            end else if (req != '0) begin
                m_found = 0;
                for (int i = 1; i <= N; i++) begin
                    if (!m_found && req[(m_last + i) % N]) begin
                        m_found = 1;
                        m_win   = (m_last + i) % N;
                    end
                end
                m_last  = m_win;
                m_job   = 1;
                m_gcyc  = cyc;
                m_start = 1'b1;
                m_gnt   = '0; m_gnt[m_win] = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [NDATA-1:0] e_x, e_s;
    always @(negedge clk) begin
        e_x = '0; e_s = '0;
        for (int r = 0; r < N; r++) begin
            if (m_gnt[r]) begin
                e_x = req_x[r*NDATA +: NDATA];
                e_s = req_sub[r*NDATA +: NDATA];
            end
        end
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("ack", 32'(ack), 32'(m_ack));
        chk("err", 32'(err), 32'(m_err));
        chk("res_start", 32'(res_start), 32'(m_start));
        chkw("y_out", y_out, m_y);
        chkw("res_x", res_x, e_x);
        chkw("res_sub", res_sub, e_s);
        if (res_start) n_start++;
    end

    // ---------------- residual unit stand-in ----------------
    int lat   = 3;
    bit stuck = 0;
    bit inj   = 0;
    int sc    = 0;
    always begin
        @(negedge clk);
        #1;
        res_done = inj;
        res_y    = rep(16'h5A5A);
        if (!rst_n) begin
            sc = 0;
        end else if (res_start) begin
            sc = lat;
        end else if (sc > 0) begin
            sc--;
            if (sc == 0 && !stuck) begin
                res_done = 1'b1;
                res_y    = sat_vec(res_x, res_sub);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic set_ops(input int r, input logic [15:0] x, input logic [15:0] s);
        req_x[r*NDATA +: NDATA]   = rep(x);
        req_sub[r*NDATA +: NDATA] = rep(s);
    endtask

    task automatic wait_gnt(input int budget);
        int k;
        k = 0;
        while (gnt == '0 && k < budget) begin
            step(1);
            k++;
        end
        checks++;
        if (gnt == '0) begin
            failures++;
            $display("FAIL wait_gnt no grant within %0d cycles", budget);
        end
    endtask

    task automatic wait_ack(input int budget, output int n);
        n = 0;
        while (ack == '0 && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (ack == '0) begin
            failures++;
            $display("FAIL wait_ack no ack within %0d cycles", budget);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL global_timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

    logic [7:0] order;
    int         n;
    int         nack;

    initial begin
        // reset with both requesting
        set_ops(0, 16'h0100, 16'h0200);
        set_ops(1, 16'h4000, 16'h4000);
        req = 2'b11;
        step(3);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_start", 32'(res_start), 32'h0);
        chkw("rst_y", y_out, '0);
        rst_n = 1'b1;
        step(1);
        chk("first_gnt", 32'(gnt), 32'h1);
        chk("first_start", 32'(res_start), 32'h1);

        // fairness: 4 jobs with both requesting
        order = '0;
        for (int j = 0; j < 4; j++) begin
            wait_gnt(10);
            order[j*2 +: 2] = gnt;
            if (j == 3) req = 2'b00;
            wait_ack(20, n);
            chkw("fair_y", y_out, (j % 2 == 0) ? rep(16'h0300) : rep(16'h7FFF));
        end
        chk("fair_order", 32'(order), 32'h99);
        chk("fair_starts", 32'(n_start), 32'd4);

        // single request from requester 1, dropped during the wait
        set_ops(1, 16'h1000, 16'h0800);
        step(2);
        req = 2'b10;
        wait_gnt(10);
        chk("single_gnt", 32'(gnt), 32'h2);
        step(1);
        req = 2'b00;
        wait_ack(20, n);
        chk("single_ack", 32'(ack), 32'h2);
        chkw("single_y", y_out, rep(16'h1800));
        step(1);
        chk("single_ack_one_cycle", 32'(ack), 32'h0);

        // negative saturation, shortest unit latency
        set_ops(0, 16'h8000, 16'hFFFF);
        lat = 1;
        step(1);
        req = 2'b01;
        wait_gnt(10);
        req = 2'b00;
        wait_ack(20, n);
        chkw("negsat_y", y_out, rep(16'h8000));

        // stale done while idle, then a done during the issue cycle
        step(2);
        inj = 1;
        step(1);
        inj = 0;
        step(3);
        chk("stale_idle_ack", 32'(ack), 32'h0);
        chkw("stale_idle_y", y_out, rep(16'h8000));
        set_ops(0, 16'h0100, 16'h0200);
        lat = 4;
        req = 2'b01;
        inj = 1;
        step(1);
        inj = 0;
        wait_ack(20, n);
        chk("stale_issue_latency", 32'(n), 32'd5);
        chkw("stale_issue_y", y_out, rep(16'h0300));
        req = 2'b00;
        step(3);

        // unit never answers
        set_ops(1, 16'h1111, 16'h1111);
        stuck = 1;
        req = 2'b10;
`ifdef RESIDUAL_ARB_WDOG_EN
        wait_ack(40, n);
        chk("wdog_latency", 32'(n), 32'd19);
        chk("wdog_ack", 32'(ack), 32'h2);
        chk("wdog_err", 32'(err), 32'h2);
        chkw("wdog_y_kept", y_out, rep(16'h0300));
`else
        nack = 0;
        for (int c = 0; c < 1000; c++) begin
            step(1);
            if (ack != '0) nack++;
        end
        chk("nowdog_no_ack", 32'(nack), 32'd0);
        chk("nowdog_still_granted", 32'(gnt), 32'h2);
`endif

        // reset in the middle of a wait
        wait_gnt(10);
        step(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'h0);
        chkw("midrst_y", y_out, '0);
        req = 2'b11;
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("midrst_next_winner", 32'(gnt), 32'h1);
        req = 2'b00;
        stuck = 0;
        lat = 2;
        wait_ack(20, n);
        chkw("post_rst_y", y_out, rep(16'h0300));
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
